// File: rtl/seq_pkg.sv
// Shared types and encodings for the phase sequencer.
package seq_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } seq_state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control and status bundle of the phase sequencer; master drives controls, slave is the sequencer.
interface phase_sequencer_if #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 4
);
    localparam int PW = $clog2(NUM_PHASES + 1);

    logic             pause;
    logic             restart;
    logic             dir;
    logic             mode;
    logic             load;
    logic [PW-1:0]    load_val;
    logic [PW-1:0]    phase;
    logic             odd;
    logic             even;
    logic             terminal;
    logic             done;
    logic             load_err;
    logic [CNT_W-1:0] passes;

    modport master (
        output pause, restart, dir, mode, load, load_val,
        input  phase, odd, even, terminal, done, load_err, passes
    );

    modport slave (
        input  pause, restart, dir, mode, load, load_val,
        output phase, odd, even, terminal, done, load_err, passes
    );

endinterface

// File: rtl/phase_sequencer_dwell_timer.sv
// Counts clocks spent in the current phase; expire marks the final clock of the phase.
module dwell_timer #(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    if (HOLD == 1) begin : g_single
        // Every clock is the last clock of its phase, so no counter exists.
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, clr, en};
        assign expire = 1'b1;
    end else begin : g_count
        localparam int CW = $clog2(HOLD);
        localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (en && cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expire = (cnt_q == LAST);
    end

endmodule

// File: rtl/phase_sequencer.sv
// Numbered-phase sequencer with hold, pause, restart, direction, one-shot, load and pass counting.
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int HOLD       = 1,
    parameter int CNT_W      = 4
) (
    input logic               clk,
    input logic               rst_n,
    phase_sequencer_if.slave  bus
);

    localparam int PW = $clog2(NUM_PHASES + 1);
    localparam logic [PW-1:0] PH_FIRST = PW'(1);
    localparam logic [PW-1:0] PH_N     = PW'(NUM_PHASES);

    seq_state_t       state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0] passes_q, passes_d;
    logic             load_err_q, load_err_d;

    logic [PW-1:0] start_ph, last_ph;
    logic          run, load_ok, step_en, at_last, expire, dwell_clr;

    dwell_timer #(.HOLD(HOLD)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (dwell_clr),
        .en     (step_en),
        .expire (expire)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        state_d    = state_q;
        phase_d    = phase_q;
        passes_d   = passes_q;
        load_err_d = 1'b0;
        dwell_clr  = 1'b0;

        start_ph = (bus.dir == DIR_DOWN) ? PH_N : PH_FIRST;
        last_ph  = (bus.dir == DIR_DOWN) ? PH_FIRST : PH_N;
        run      = (state_q == RUN);
        load_ok  = (bus.load_val != '0) && (bus.load_val <= PH_N);
        step_en  = run && !bus.restart && !bus.load && !bus.pause;
        at_last  = (phase_q == last_ph);

        if (bus.restart) begin
            state_d   = RUN;
            phase_d   = start_ph;
            dwell_clr = 1'b1;
        end else if (bus.load) begin
            if (load_ok) begin
                state_d   = RUN;
                phase_d   = bus.load_val;
                dwell_clr = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_en && expire) begin
            dwell_clr = 1'b1;
            if (!at_last) begin
                phase_d = (bus.dir == DIR_DOWN) ? phase_q - 1'b1 : phase_q + 1'b1;
            end else begin
                if (passes_q != '1) passes_d = passes_q + 1'b1;
                if (bus.mode == MODE_WRAP) begin
                    phase_d = start_ph;
                end else begin
                    state_d = DONE;
                    phase_d = '0;
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            phase_q    <= PH_FIRST;
            passes_q   <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            passes_q   <= passes_d;
            load_err_q <= load_err_d;
        end
    end

    // A restart in the last phase still closes the pass, though it is not counted.
    assign bus.terminal = run && at_last &&
                          (bus.restart || (!bus.pause && !bus.load && expire));
    assign bus.phase    = phase_q;
    assign bus.odd      = phase_q[0];
    assign bus.even     = (phase_q != '0) && !phase_q[0];
    assign bus.done     = (state_q == DONE);
    assign bus.load_err = load_err_q;
    assign bus.passes   = passes_q;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Parametrised successor to the three-state odd/even sequencer: cycles through `NUM_PHASES` numbered phases.
- Each phase is held for `HOLD` clocks.
- Adds pause, restart, run direction, wrap or one-shot mode, parallel load and a saturating pass counter.
- Drives phase-qualified datapath enables; the `terminal` flag marks the cycle a pass completes.

## Interface
- `NUM_PHASES`, 3: number of phases; must be ≥2.
- `HOLD`, 1: clocks spent in each phase; must be ≥1.
- `CNT_W`, 4: pass counter width; must be ≥1.
- `PW` (localparam), `$clog2(NUM_PHASES+1)`: phase width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pause` in 1: hold current phase and dwell count.
- `restart` in 1: return to the start phase.
- `dir` in 1: 0 = up (1→N), 1 = down (N→1).
- `mode` in 1: 0 = wrap, 1 = one-shot.
- `load` in 1: load phase from `load_val`.
- `load_val` in PW: target phase, legal 1..N.
- `phase` out PW: current phase 1..N; 0 when DONE.
- `odd` out 1: `phase` odd (`phase[0]`), 0 when DONE.
- `even` out 1: `phase` nonzero and even.
- `terminal` out 1: combinational; the pass completes this cycle.
- `done` out 1: one-shot finished.
- `load_err` out 1: registered one-cycle pulse on an out-of-range load.
- `passes` out CNT_W: completed passes, saturating.

## Operation
- States:
  - RUN: `phase` is 1..N.
  - DONE: reached only in one-shot mode.
- Start phase S = 1 if `dir`=0, else N. Last phase L = N if `dir`=0, else 1. Both use the current-cycle `dir`.
- Internal `dwell` counts 0..HOLD-1 and is cleared on every phase change.
- Per-edge priority, highest first:
  1. `restart`: `phase`←S, `dwell`←0, leave DONE.
  2. `load`:
     - `load_val` in 1..N: `phase`←`load_val`, `dwell`←0, leave DONE.
     - Otherwise: state unchanged, `load_err`=1 next cycle.
  3. `pause`: RUN holds `phase` and `dwell`.
  4. In RUN, `dwell`<HOLD-1: `dwell`++.
  5. In RUN, `dwell`=HOLD-1, `phase`≠L: step `phase` by ±1 per `dir`, `dwell`←0.
  6. In RUN, `dwell`=HOLD-1, `phase`=L: `passes`++ (saturating at all-ones), then:
     - `mode`=0: `phase`←S.
     - `mode`=1: go to DONE.
- DONE holds until `restart` or a legal `load`; `pause` has no effect there.
- `terminal` = RUN & `phase`=L & (`restart` | (!`pause` & !`load` & `dwell`=HOLD-1)).
  - A restart in the last phase still asserts `terminal` but does not increment `passes`.
- Changing `dir` mid-pass takes effect on the next step. Example: up at phase 2 with `dir`→1 gives 2→1.
- `passes` is cleared only by `rst_n`. `restart` and `load` leave it unchanged.

## Timing
- Reset values: `phase`=1, `dwell`=0, state RUN, `passes`=0, `load_err`=0.
  - Derived outputs after reset: `odd`=1, `even`=0, `done`=0, `terminal` depends on inputs.
- Reset asserted mid-pass forces these values immediately, with no clock edge needed.
- `phase`, `done`, `passes`, `load_err` are registered and update one edge after the qualifying cycle.
- `odd`, `even` decode registered `phase` only.
- `terminal` is the only output with an input-to-output combinational path.
- Unpaused full pass takes N·HOLD clocks. In wrap mode the sequence period is exactly N·HOLD.
- With `HOLD`=1, the phase advances every unpaused cycle.

## Structure
- Package `seq_pkg`:
  - `seq_state_t` enum {RUN, DONE}.
  - Constants `DIR_UP`/`DIR_DOWN`, `MODE_WRAP`/`MODE_ONESHOT`.
- Sub-module `dwell_timer`: parameter `HOLD`; inputs `clr`, `en`; output `expire` (= count at HOLD-1).
  - Elaborates to constant `expire`=1 when `HOLD`=1.
- Top level contains the phase register, state register, next-phase logic and pass counter.

## Test plan
All scenarios use N=3, HOLD=2, CNT_W=2 unless stated.
- Reset release, all inputs 0, up/wrap: `phase` sequence 1,1,2,2,3,3,1.
  - `terminal`=1 on the second cycle of phase 3.
  - `passes` goes 0→1 after 6 clocks.
- `pause` held 4 cycles in phase 2, dwell 1: `phase` stays 2 throughout; advances to 3 one clock after release.
- One-shot, down: sequence 3,3,2,2,1,1, then DONE.
  - In DONE: `phase`=0, `done`=1, `odd`=`even`=0.
  - `restart` returns to phase 3 next edge.
- `load`=1 with `load_val`=3 from phase 1: `phase`=3 next edge. `load_val`=0: `phase` unchanged, `load_err` pulses one cycle.
- `restart`, `load` and `pause` all asserted in phase 3: restart wins, `phase`=1, `terminal`=1 that cycle, `passes` unchanged.
- CNT_W=2, run 5 full passes: `passes` saturates at 3. Then `rst_n` low mid-pass: all outputs return to reset values asynchronously.
